// File: rtl/tpu_seq_pkg.sv
// Shared types and widths for the TPU MAC sequencing logic.
// Holds the sequencer state encoding and the operand/accumulator widths.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    READ_HI,
    READ_LO,
    RESULT
  } seq_state_e;

  localparam int OP_W   = 8;
  localparam int ACC_W  = 32;
  localparam int HALF_W = 16;

endpackage

// File: rtl/mac_sequencer.sv
// Feeds operand pairs into an external MAC, then reads its 32-bit accumulator
// back one half at a time and presents it on a valid/ready result port.
module mac_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              mac_clear,
  output logic [OP_W-1:0]   mac_in1,
  output logic [OP_W-1:0]   mac_in2,
  output logic              mac_out_HL,
  input  logic [HALF_W-1:0] mac_out,
  input  logic              mac_error,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_error,
  output logic              busy
);

  seq_state_e       state;
  seq_state_e       state_nxt;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_inc;
  logic [LEN_W-1:0] len_q;
  logic             err;
  logic             accept;

  assign count_inc = count + {{(LEN_W-1){1'b0}}, 1'b1};
  assign accept    = in_valid & in_ready;
  assign busy      = (state != IDLE);
  assign res_error = err;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    mac_clear  = 1'b0;
    mac_out_HL = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        mac_clear = 1'b1;
        if (start) state_nxt = (len == '0) ? DRAIN : ACCUM;
      end
      ACCUM: begin
        in_ready = (count < len_q);
        if (in_valid && in_ready && (count_inc == len_q)) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = READ_HI;
      READ_HI: begin
        mac_out_HL = 1'b1;
        state_nxt  = READ_LO;
      end
      READ_LO: state_nxt = RESULT;
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The MAC adds every cycle, so operands fall back to zero whenever no pair is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      len_q    <= '0;
      err      <= 1'b0;
      mac_in1  <= '0;
      mac_in2  <= '0;
      res_data <= '0;
    end else begin
      mac_in1 <= '0;
      mac_in2 <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            len_q <= len;
            err   <= 1'b0;
          end
        end
        ACCUM: begin
          err <= err | mac_error;
          if (accept) begin
            mac_in1 <= in_a;
            mac_in2 <= in_b;
            count   <= count_inc;
          end
        end
        DRAIN:   err <= err | mac_error;
        READ_HI: res_data[ACC_W-1:HALF_W] <= mac_out;
        READ_LO: res_data[HALF_W-1:0]     <= mac_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed scoreboard bench for mac_sequencer with a two-valued stub MAC.
// Expected results are queued at job start and popped on each result handshake.
module tb_mac_sequencer;
  import tpu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'h00;
  logic [7:0]  in_b = 8'h00;
  logic        mac_clear;
  logic [7:0]  mac_in1;
  logic [7:0]  mac_in2;
  logic        mac_out_HL;
  logic [15:0] mac_out;
  logic        mac_error = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_error;
  logic        busy;

  logic [15:0] hi_val = 16'h1234;
  logic [15:0] lo_val = 16'h5678;
  logic [7:0]  pa [8] = '{8'h11, 8'h33, 8'h55, 8'h21, 8'h43, 8'h65, 8'h07, 8'h19};
  logic [7:0]  pb [8] = '{8'h22, 8'h44, 8'h66, 8'h12, 8'h34, 8'h56, 8'h70, 8'h91};
  logic [32:0] exp_q [$];

  int vectors = 0;
  int miscompares = 0;

  mac_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_clear(mac_clear), .mac_in1(mac_in1), .mac_in2(mac_in2),
    .mac_out_HL(mac_out_HL), .mac_out(mac_out), .mac_error(mac_error),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_error(res_error), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mac_out = mac_out_HL ? hi_val : lo_val;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: sampled on the falling edge, ahead of the consuming posedge.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_result", 64'({res_error, res_data}), 64'h1_dead_beef);
      end else begin
        check_output("result", 64'({res_error, res_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic apply_stimulus(input int n, input int stall_at, input int err_at,
                                input int hold, input logic [15:0] hi, input logic [15:0] lo);
    int  i;
    int  cyc;
    bit  stalled;
    hi_val = hi;
    lo_val = lo;
    exp_q.push_back({(err_at >= 0), hi, lo});
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    check_output("busy_after_start", 64'(busy), 64'd1);
    check_output("clear_after_start", 64'(mac_clear), 64'd0);
    if (n == 0) check_output("no_ready_len0", 64'(in_ready), 64'd0);
    i = 0;
    stalled = 1'b0;
    while (i < n) begin
      if (i == stall_at && !stalled) begin
        stalled  = 1'b1;
        in_valid = 1'b0;
        tick();
        check_output("stall_op_zero", 64'({mac_in1, mac_in2}), 64'd0);
        check_output("stall_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid  = 1'b1;
        in_a      = pa[i];
        in_b      = pb[i];
        mac_error = (i == err_at);
        tick();
        mac_error = 1'b0;
        check_output("op_pair", 64'({mac_in1, mac_in2}), 64'({pa[i], pb[i]}));
        i++;
      end
    end
    in_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 10) begin
      check_output("clear_low_wait", 64'(mac_clear), 64'd0);
      check_output("half_select", 64'(mac_out_HL), (cyc == 1) ? 64'd1 : 64'd0);
      if (cyc >= 1) check_output("op_zero_drain", 64'({mac_in1, mac_in2}), 64'd0);
      tick();
      cyc++;
    end
    check_output("latency", 64'(cyc), 64'd3);
    for (int k = 0; k < hold; k++) begin
      start = 1'b1;
      len   = 8'd2;
      tick();
      check_output("hold_valid", 64'(res_valid), 64'd1);
      check_output("hold_data", 64'(res_data), 64'({hi, lo}));
      check_output("hold_ops", 64'({mac_in1, mac_in2, mac_clear}), 64'd0);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_output("idle_after_result", 64'({busy, mac_clear, res_valid}), 64'b010);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    start = 1'b1;
    len   = 8'd3;
    tick();
    tick();
    check_output("reset_idle", 64'({busy, mac_clear, in_ready, res_valid, mac_out_HL}), 64'b01000);
    check_output("reset_regs", 64'({mac_in1, mac_in2, res_data}), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check_output("start_with_reset_dropped", 64'(busy), 64'd0);

    apply_stimulus(3, -1, -1, 0, 16'h1234, 16'h5678);
    apply_stimulus(0, -1, -1, 0, 16'h1234, 16'h5678);
    apply_stimulus(4, 2, 1, 0, 16'hABCD, 16'h0F0F);
    apply_stimulus(2, -1, -1, 10, 16'h8001, 16'h7FFE);

    // Reset in the middle of a five-pair job, with start held during reset.
    start = 1'b1;
    len   = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      tick();
    end
    reset = 1'b1;
    tick();
    check_output("mid_reset_state", 64'({busy, mac_clear, in_ready}), 64'b010);
    check_output("mid_reset_ops", 64'({mac_in1, mac_in2}), 64'd0);
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    check_output("start_during_reset", 64'(busy), 64'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    check_output("idle_after_reset", 64'(busy), 64'd0);

    apply_stimulus(1, -1, -1, 0, 16'h5A5A, 16'hA5A5);

    tick();
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
